// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory read port, redirect input and the
// decode-facing valid/ready stream. The fetch controller uses the master view.
interface ifetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues word reads to a 1-cycle instruction
// memory, buffers returned words with their PCs and flushes the stream on redirect.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  ifetch_ctrl_if.master bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = AW + 2;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     rsp_pc;
  logic            inflight;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CNTW-1:0] count;
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [31:0]     fifo_pc    [FIFO_DEPTH];

  logic          redir;
  logic          pop;
  logic          push;
  logic          req;
  logic [CW-1:0] credit;

  assign redir  = bus.redirect_valid;
  assign pop    = (count != '0) && bus.out_ready;
  // A redirect clears the buffer, so the response landing this cycle is dropped.
  assign push   = inflight && !redir;
  // Counting the slot freed by this cycle's pop lets depth 2 sustain 1 instr/cycle;
  // a full buffer still blocks requests outright.
  assign credit = CW'(count) + CW'(inflight) - CW'(pop);
  assign req    = (state == RUN) && !redir &&
                  (count != CNTW'(FIFO_DEPTH)) && (credit < CW'(FIFO_DEPTH));

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = fifo_instr[rd_ptr];
  assign bus.out_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC & 32'hFFFF_FFFC;
      rsp_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= 32'h0000_0013;
        fifo_pc[i]    <= '0;
      end
    end else begin
      inflight <= req;
      if (req) begin
        pc     <= pc + 32'd4;
        rsp_pc <= pc;
      end
      if (push) begin
        fifo_instr[wr_ptr] <= bus.imem_rdata;
        fifo_pc[wr_ptr]    <= rsp_pc;
      end
      if (redir) begin
        pc     <= bus.redirect_pc & 32'hFFFF_FFFC;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        state  <= (state == BOOT) ? RUN : FLUSH;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNTW'(push) - CNTW'(pop);
        case (state)
          BOOT:    state <= RUN;
          FLUSH:   state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: the driver pushes the expected PC stream for each
// (re)start into a scoreboard; a negedge monitor pops and compares on every handshake.
module tb_ifetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          SEG_LEN  = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          epoch;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];
  int   drv_epoch = 0;
  int   mon_epoch = 0;
  int   checks    = 0;
  int   failures  = 0;
  bit   armed     = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: word returned exactly one cycle after the request, garbage otherwise.
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : $urandom;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // A new fetch stream: consecutive word PCs from the aligned start address.
  task automatic start_stream(input logic [31:0] pc0);
    logic [31:0] p;
    p = pc0 & 32'hFFFF_FFFC;
    drv_epoch++;
    for (int i = 0; i < SEG_LEN; i++) begin
      sbq.push_back('{drv_epoch, p});
      p = p + 32'd4;
    end
  endtask

  task automatic issue_redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    start_stream(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.imem_req),  32'd0);
    check({tag, "_addr"},  bus.imem_addr,      RESET_PC);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_instr"}, bus.out_instr,      32'h0000_0013);
    check({tag, "_pc"},    bus.out_pc,         32'd0);
  endtask

  // Monitor
  exp_t        e;
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic        prev_boot  = 1'b0;
  logic [31:0] prev_pc, prev_instr;
  int          since_rst  = 0;
  bit          in_rst     = 1'b0;

  always @(negedge clk or posedge rst) begin
    if (armed) begin
      if (rst) begin
        if (!in_rst) begin
          mon_epoch++;
          in_rst = 1'b1;
        end
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        prev_boot  = 1'b0;
        since_rst  = 0;
      end else begin
        in_rst = 1'b0;
        if (prev_stall) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_pc",    bus.out_pc,    prev_pc);
          check("hold_instr", bus.out_instr, prev_instr);
        end
        if (since_rst == 0 || bus.redirect_valid || (prev_redir && !prev_boot))
          check("quiet_req", 32'(bus.imem_req), 32'd0);
        if (bus.imem_req)
          check("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
          while (sbq.size() > 0 && sbq[0].epoch != mon_epoch) sbq.delete(0);
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got pc %h expected no handshake", bus.out_pc);
          end else begin
            e = sbq.pop_front();
            check("out_pc",    bus.out_pc,    e.pc);
            check("out_instr", bus.out_instr, mem_word(e.pc));
          end
        end
        if (bus.redirect_valid) mon_epoch++;
        prev_stall = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
        prev_pc    = bus.out_pc;
        prev_instr = bus.out_instr;
        prev_redir = bus.redirect_valid;
        prev_boot  = (since_rst == 0);
        since_rst++;
      end
    end
  end

  // Driver
  initial begin
    int          n;
    int          nreq;
    bit          hold_ok;
    logic [31:0] ref_pc, ref_instr, t;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    #2;
    armed = 1'b1;
    rst   = 1'b1;
    start_stream(RESET_PC);
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot_req", 32'(bus.imem_req), 32'd0);
    cyc(); bus.out_ready = 1'b1; #1;
    check("first_req",  32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, RESET_PC);
    cyc(); #1;
    check("lat_c2_valid", 32'(bus.out_valid), 32'd0);
    cyc(); #1;
    check("lat_c3_valid", 32'(bus.out_valid), 32'd1);
    check("lat_c3_pc",    bus.out_pc, RESET_PC);

    n = 0;
    repeat (16) begin
      cyc(); #1;
      if (bus.out_valid) n++;
    end
    check("throughput", 32'(n), 32'd16);

    // decode stalls for 6 cycles
    cyc(); bus.out_ready = 1'b0; #1;
    ref_pc    = bus.out_pc;
    ref_instr = bus.out_instr;
    nreq      = int'(bus.imem_req);
    hold_ok   = bus.out_valid;
    repeat (5) begin
      cyc(); #1;
      nreq += int'(bus.imem_req);
      if (!bus.out_valid || bus.out_pc !== ref_pc || bus.out_instr !== ref_instr) hold_ok = 1'b0;
    end
    check("stall_reqs_le2", 32'(nreq <= 2), 32'd1);
    check("stall_hold",     32'(hold_ok),   32'd1);
    cyc(); bus.out_ready = 1'b1;
    repeat (6) cyc();

    // redirect with buffer occupied and a response in flight
    cyc(); bus.out_ready = 1'b0; issue_redirect(32'h0000_0103); #1;
    check("redir_req", 32'(bus.imem_req), 32'd0);
    cyc(); bus.redirect_valid = 1'b0; bus.out_ready = 1'b1; #1;
    check("flush_req",   32'(bus.imem_req),  32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    cyc(); #1;
    check("redir_first_req",  32'(bus.imem_req), 32'd1);
    check("redir_first_addr", bus.imem_addr, 32'h0000_0100);
    cyc(); cyc(); #1;
    check("redir_out_valid", 32'(bus.out_valid), 32'd1);
    check("redir_out_pc",    bus.out_pc, 32'h0000_0100);

    // redirect coinciding with a handshake
    repeat (4) cyc();
    cyc(); issue_redirect(32'h0000_2000); #1;
    check("hs_redir_valid", 32'(bus.out_valid), 32'd1);
    cyc(); bus.redirect_valid = 1'b0;
    repeat (3) cyc();
    #1;
    check("hs_redir_next_pc", bus.out_pc, 32'h0000_2000);

    // 32-bit PC wrap
    cyc(); issue_redirect(32'hFFFF_FFF8);
    cyc(); bus.redirect_valid = 1'b0;
    repeat (3) cyc();
    #1; check("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
    cyc(); #1; check("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
    cyc(); #1; check("wrap_pc2", bus.out_pc, 32'h0000_0000);

    // asynchronous reset between clock edges
    repeat (3) cyc();
    #1; check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    start_stream(RESET_PC);
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_boot_req", 32'(bus.imem_req), 32'd0);
    cyc(); #1;
    check("rst2_req",  32'(bus.imem_req), 32'd1);
    check("rst2_addr", bus.imem_addr, RESET_PC);

    // random traffic
    repeat (2000) begin
      cyc();
      bus.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) begin
        t = ($urandom_range(1) == 0) ? 32'($urandom) : 32'hFFFF_FFE0 + 32'($urandom_range(31));
        issue_redirect(t);
      end else begin
        bus.redirect_valid = 1'b0;
      end
    end
    cyc();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    repeat (10) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
